// File: rtl/cla_pkg.sv
// Shared definitions for the multi-cycle carry-lookahead subtractor:
// slice width, FSM state encoding and the slice-count helper.
package cla_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } sub_state_t;

   // Number of SLICE_W-bit slices needed to cover an operand of the given width
   function automatic int slice_count(input int width);
      return width / SLICE_W;
   endfunction

endpackage : cla_pkg

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice: s = x + y + ci, co = carry out.
// Carries are formed directly from generate/propagate terms rather than rippled.
module cla4_slice (
   input  logic [3:0] x,
   input  logic [3:0] y,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);

   logic [3:0] w_g;
   logic [3:0] w_p;
   logic [4:0] w_c;

   assign w_g = x & y;
   assign w_p = x ^ y;

   // Lookahead carries, each expressed only in terms of g/p and ci
   assign w_c[0] = ci;
   assign w_c[1] = w_g[0] | (w_p[0] & ci);
   assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & ci);
   assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                 | (w_p[2] & w_p[1] & w_p[0] & ci);
   assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                 | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & ci);

   assign s  = w_p ^ w_c[3:0];
   assign co = w_c[4];

endmodule : cla4_slice

// File: rtl/multiword_cla_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit CLA slice per clock,
// computed as a + ~b + ~bin with the borrow carried between slices in a register.
// Optional feature macro: SUB_OVF_EN enables the signed overflow flag on ovf;
// without it ovf is tied to 0.
module multiword_cla_subtractor
   import cla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   localparam int N     = slice_count(WIDTH);
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   generate
      if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_check
         $error("multiword_cla_subtractor: WIDTH must be a positive multiple of 4");
      end
   endgenerate

   sub_state_t          r_state;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic [WIDTH-1:0]    r_a;
   logic [WIDTH-1:0]    r_b;
   logic [WIDTH-1:0]    r_diff;
   logic                r_bout;
   logic                r_busy;
   logic                r_done;

   logic [SLICE_W-1:0]  w_x;
   logic [SLICE_W-1:0]  w_y;
   logic [SLICE_W-1:0]  w_s;
   logic                w_co;
   logic                w_last;

   // Current slice of the captured operands; the subtrahend is inverted so the
   // adder slice performs subtraction.
   assign w_x    = r_a[r_idx*SLICE_W +: SLICE_W];
   assign w_y    = ~r_b[r_idx*SLICE_W +: SLICE_W];
   assign w_last = (r_idx == LAST_IDX);

   cla4_slice u_slice (
      .x  (w_x),
      .y  (w_y),
      .ci (r_carry),
      .s  (w_s),
      .co (w_co)
   );

`ifdef SUB_OVF_EN
   logic r_ovf;
   logic w_ovf_next;

   // Signs differ and the result sign disagrees with the minuend; the result
   // sign is the top bit of the final slice being written this cycle.
   assign w_ovf_next = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_s[SLICE_W-1] != r_a[WIDTH-1]);

   // Overflow flag, updated only on the transition into DONE
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovf <= 1'b0;
      end else if (r_state == BUSY && w_last) begin
         r_ovf <= w_ovf_next;
      end
   end

   assign ovf = r_ovf;
`else
   assign ovf = 1'b0;
`endif

   // Operand capture on an accepted start; held untouched while slices run
   always_ff @(posedge clk) begin
      if (r_state == IDLE && start && !rst) begin
         r_a <= a;
         r_b <= b;
      end
   end

   // Control FSM, slice index, borrow chain and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= BUSY;
                  r_idx   <= '0;
                  r_carry <= ~bin;
                  r_busy  <= 1'b1;
               end
            end
            BUSY: begin
               r_diff[r_idx*SLICE_W +: SLICE_W] <= w_s;
               r_carry <= w_co;
               if (w_last) begin
                  r_state <= DONE;
                  r_idx   <= '0;
                  r_bout  <= ~w_co;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_done  <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_idx   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = r_busy;
   assign done = r_done;
   assign diff = r_diff;
   assign bout = r_bout;

endmodule : multiword_cla_subtractor
